pcpi_systolic_mac_array: RTL

//  PicoRV32 PCPI coprocessor: parametrised NxN output-stationary systolic multiply-accumulate array.

---
 rtl/pcpi_systolic_mac_array.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pcpi_systolic_mac_array.sv
// PCPI coprocessor: NxN output-stationary systolic MAC array computing C = A*B + BIAS,
// thresholded into an N*N bitmap, plus accumulator/bitmap/status readback and clear.
//
// state     | meaning
// IDLE      | waiting for an instruction
// EXEC      | single-cycle operation executes, ready pulse issued
// LOAD_BIAS | C preloaded with BIAS, skew pipeline flushed
// COMPUTE   | 3N-2 skewed multiply-accumulate cycles
// RESP      | C compared against THRESH into bitmap, DONE set
// ACK       | bitmap returned with ready/wr pulse
module pcpi_systolic_mac_array #(
   parameter int N          = 3,
   parameter int DATA_W     = 16,
   parameter int ACC_W      = 32,
   parameter int THRESH_RST = -70
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        pcpi_valid,
   input  logic [31:0] pcpi_insn,
   input  logic [31:0] pcpi_rs1,
   input  logic [31:0] pcpi_rs2,
   output logic        pcpi_wr,
   output logic [31:0] pcpi_rd,
   output logic        pcpi_wait,
   output logic        pcpi_ready
);
   localparam int NN    = N * N;
   localparam int CNT_W = $clog2(3 * N);
   localparam logic [6:0] OPC = 7'b0001011;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] EXEC      = 3'd1;
   localparam logic [2:0] LOAD_BIAS = 3'd2;
   localparam logic [2:0] COMPUTE   = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;
   localparam logic [2:0] ACK       = 3'd5;

   localparam logic [2:0] F_LOAD   = 3'b000;
   localparam logic [2:0] F_READC  = 3'b001;
   localparam logic [2:0] F_READM  = 3'b010;
   localparam logic [2:0] F_STATUS = 3'b011;
   localparam logic [2:0] F_CLEAR  = 3'b101;
   localparam logic [2:0] F_START  = 3'b111;

   logic [2:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [2:0]              op_q;
   logic [31:0]             idx_q, val_q;
   logic signed [DATA_W-1:0] a_mem_q [NN];
   logic signed [DATA_W-1:0] b_mem_q [NN];
   logic signed [DATA_W-1:0] bias_q  [NN];
   logic signed [DATA_W-1:0] a_pipe_q [NN];
   logic signed [DATA_W-1:0] b_pipe_q [NN];
   logic signed [ACC_W-1:0]  c_q [NN];
   logic signed [ACC_W-1:0]  thresh_q;
   logic [NN-1:0]           bitmap_q;
   logic                    done_q, ready_q, wr_q, wait_q;
   logic [31:0]             rd_q;

   logic [2:0]              funct3;
   logic                    accept, busy;
   logic signed [DATA_W-1:0] feed_a [N];
   logic signed [DATA_W-1:0] feed_b [N];
   logic signed [DATA_W-1:0] a_in [NN];
   logic signed [DATA_W-1:0] b_in [NN];
   logic signed [2*DATA_W-1:0] prod [NN];
   logic [NN-1:0]           ge;
   logic [31:0]             readc_val;
   logic                    unused_insn;

   assign funct3      = pcpi_insn[14:12];
   assign unused_insn = ^{pcpi_insn[31:15], pcpi_insn[11:7]};
   // ready_q still high means the core has not yet seen the previous completion
   assign accept = pcpi_valid && (pcpi_insn[6:0] == OPC) && (state_q == IDLE) && !ready_q
                   && (funct3 != 3'b100) && (funct3 != 3'b110);
   assign busy   = (state_q == LOAD_BIAS) || (state_q == COMPUTE) || (state_q == RESP) || (state_q == ACK);

   always_comb begin
      for (int r = 0; r < N; r++) begin
         feed_a[r] = '0;
         feed_b[r] = '0;
         for (int k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(r + k)) begin
               feed_a[r] = a_mem_q[r*N + k];
               feed_b[r] = b_mem_q[k*N + r];
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         if (j == 0) begin : g_a_edge
            assign a_in[i*N + j] = feed_a[i];
         end else begin : g_a_hop
            assign a_in[i*N + j] = a_pipe_q[i*N + j - 1];
         end
         if (i == 0) begin : g_b_edge
            assign b_in[i*N + j] = feed_b[j];
         end else begin : g_b_hop
            assign b_in[i*N + j] = b_pipe_q[(i-1)*N + j];
         end
         assign prod[i*N + j] = (2*DATA_W)'(a_in[i*N + j]) * (2*DATA_W)'(b_in[i*N + j]);
         assign ge[i*N + j]   = c_q[i*N + j] >= thresh_q;
      end
   end

   always_comb begin
      readc_val = '0;
      for (int e = 0; e < NN; e++) begin
         if (idx_q == 32'(e)) readc_val = 32'(c_q[e]);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = (funct3 == F_START) ? LOAD_BIAS : EXEC;
         EXEC:      state_d = IDLE;
         LOAD_BIAS: state_d = COMPUTE;
         COMPUTE:   if (cnt_q == CNT_W'(3*N - 3)) state_d = RESP;
         RESP:      state_d = ACK;
         ACK:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         idx_q    <= '0;
         val_q    <= '0;
         thresh_q <= ACC_W'(THRESH_RST);
         bitmap_q <= '0;
         done_q   <= 1'b0;
         ready_q  <= 1'b0;
         wr_q     <= 1'b0;
         wait_q   <= 1'b0;
         rd_q     <= '0;
         for (int e = 0; e < NN; e++) begin
            a_mem_q[e]  <= '0;
            b_mem_q[e]  <= '0;
            bias_q[e]   <= '0;
            a_pipe_q[e] <= '0;
            b_pipe_q[e] <= '0;
            c_q[e]      <= '0;
         end
      end else begin
         state_q <= state_d;
         ready_q <= 1'b0;
         wr_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q  <= funct3;
                  idx_q <= pcpi_rs1;
                  val_q <= pcpi_rs2;
               end
            end
            EXEC: begin
               ready_q <= 1'b1;
               case (op_q)
                  F_LOAD: begin
                     rd_q <= '0;
                     for (int e = 0; e < NN; e++) begin
                        if (idx_q == 32'(e))          a_mem_q[e] <= val_q[DATA_W-1:0];
                        if (idx_q == 32'(NN + e))     b_mem_q[e] <= val_q[DATA_W-1:0];
                        if (idx_q == 32'(2*NN + e))   bias_q[e]  <= val_q[DATA_W-1:0];
                     end
                     if (idx_q == 32'(3*NN)) thresh_q <= val_q[ACC_W-1:0];
                  end
                  F_READC: begin
                     rd_q <= readc_val;
                     wr_q <= 1'b1;
                  end
                  F_READM: begin
                     rd_q <= 32'(bitmap_q);
                     wr_q <= 1'b1;
                  end
                  F_STATUS: begin
                     rd_q <= {30'd0, busy, done_q};
                     wr_q <= 1'b1;
                  end
                  F_CLEAR: begin
                     rd_q     <= '0;
                     done_q   <= 1'b0;
                     bitmap_q <= '0;
                  end
                  default: rd_q <= rd_q;
               endcase
            end
            LOAD_BIAS: begin
               wait_q <= 1'b1;
               cnt_q  <= '0;
               for (int e = 0; e < NN; e++) begin
                  c_q[e]      <= ACC_W'(bias_q[e]);
                  a_pipe_q[e] <= '0;
                  b_pipe_q[e] <= '0;
               end
            end
            COMPUTE: begin
               cnt_q <= cnt_q + 1'b1;
               for (int e = 0; e < NN; e++) begin
                  c_q[e]      <= c_q[e] + ACC_W'(prod[e]);
                  a_pipe_q[e] <= a_in[e];
                  b_pipe_q[e] <= b_in[e];
               end
            end
            RESP: begin
               bitmap_q <= ge;
               done_q   <= 1'b1;
            end
            ACK: begin
               rd_q    <= 32'(bitmap_q);
               ready_q <= 1'b1;
               wr_q    <= 1'b1;
               wait_q  <= 1'b0;
            end
            default: wait_q <= 1'b0;
         endcase
      end
   end

   assign pcpi_wr    = wr_q;
   assign pcpi_rd    = rd_q;
   assign pcpi_wait  = wait_q;
   assign pcpi_ready = ready_q;
endmodule
